// File: rtl/issue_ctrl.sv
// issue_ctrl: dual-issue scheduler between the instruction queue and the pipe0/pipe1 issue->ID2 registers.
//   Optional feature macro: ISSUE_PERF_CNT_EN enables the perf_dual/perf_single cycle counters.
//   Ports: clk, rst (sync, active-high), stall, flush (EX redirect), exception_flush,
//          q_valid[1:0] and q0_*/q1_* head/head+1 decode fields (rs, rt, wen, dst, br, mem, priv),
//          pop (entries consumed), q_flush, pipe_flush, iss0/iss1_valid, iss0/iss1_in_ds,
//          ds_pending, perf_dual, perf_single.
module issue_ctrl #(
    parameter bit DUAL_ISSUE = 1'b1,
    parameter bit MEM_DUAL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        exception_flush,
    input  logic [1:0]  q_valid,
    input  logic [4:0]  q0_rs,
    input  logic [4:0]  q0_rt,
    input  logic        q0_wen,
    input  logic [4:0]  q0_dst,
    input  logic        q0_br,
    input  logic        q0_mem,
    input  logic        q0_priv,
    input  logic [4:0]  q1_rs,
    input  logic [4:0]  q1_rt,
    input  logic        q1_wen,
    input  logic [4:0]  q1_dst,
    input  logic        q1_br,
    input  logic        q1_mem,
    input  logic        q1_priv,
    output logic [1:0]  pop,
    output logic        q_flush,
    output logic        pipe_flush,
    output logic        iss0_valid,
    output logic        iss1_valid,
    output logic        iss0_in_ds,
    output logic        iss1_in_ds,
    output logic        ds_pending,
    output logic [31:0] perf_dual,
    output logic [31:0] perf_single
);
    typedef enum logic [1:0] {RUN = 2'd0, WAIT_DS = 2'd1} state_t;
    state_t state, state_n;
    logic flush_pend, flush_pend_n;
    logic hazard, pair_ok;
    logic unused_srcs;
    assign unused_srcs = ^{q0_rs, q0_rt};
    // $0 writes are discarded, so they never create a dependency
    assign hazard = q0_wen && q0_dst != 5'd0 &&
                    (q1_rs == q0_dst || q1_rt == q0_dst || (q1_wen && q1_dst == q0_dst));
    // slot1 has no HI/LO/CP0 path and may not hold a branch
    assign pair_ok = DUAL_ISSUE && q_valid[1] && !q1_br && !q1_priv &&
                     !(q0_mem && q1_mem && !MEM_DUAL) && !hazard;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_n;
            flush_pend <= flush_pend_n;
        end
    end
    always_comb begin
        state_n      = state;
        flush_pend_n = flush_pend;
        pop          = 2'd0;
        q_flush      = 1'b0;
        pipe_flush   = 1'b0;
        iss0_valid   = 1'b0;
        iss1_valid   = 1'b0;
        iss0_in_ds   = 1'b0;
        iss1_in_ds   = 1'b0;
        if (rst) begin
            state_n      = RUN;
            flush_pend_n = 1'b0;
        end else if (exception_flush) begin
            q_flush      = 1'b1;
            pipe_flush   = 1'b1;
            state_n      = RUN;
            flush_pend_n = 1'b0;
        end else if (stall) begin
            state_n = state;
        end else if (state == RUN) begin
            if (flush) begin
                q_flush    = 1'b1;
                pipe_flush = 1'b1;
            end else if (q_valid[0]) begin
                pop        = pair_ok ? 2'd2 : 2'd1;
                iss0_valid = 1'b1;
                iss1_valid = pair_ok;
                iss1_in_ds = pair_ok && q0_br;
                state_n    = (q0_br && !pair_ok) ? WAIT_DS : RUN;
            end
        end else if (q_valid[0]) begin
            // delay slot issues alone; a redirect seen meanwhile now drops the wrong path
            pop          = 2'd1;
            iss0_valid   = 1'b1;
            iss0_in_ds   = 1'b1;
            q_flush      = flush_pend || flush;
            flush_pend_n = 1'b0;
            state_n      = RUN;
        end else begin
            flush_pend_n = flush_pend || flush;
        end
    end
    assign ds_pending = !rst && state == WAIT_DS;
`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] dual_cnt, single_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            dual_cnt   <= 32'd0;
            single_cnt <= 32'd0;
        end else begin
            dual_cnt   <= dual_cnt + {31'd0, pop == 2'd2};
            single_cnt <= single_cnt + {31'd0, pop == 2'd1};
        end
    end
    assign perf_dual   = rst ? 32'd0 : dual_cnt;
    assign perf_single = rst ? 32'd0 : single_cnt;
`else
    assign perf_dual   = 32'd0;
    assign perf_single = 32'd0;
`endif
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed self-checking bench for issue_ctrl.
module tb_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst, stall, flush, exception_flush;
    logic [1:0]  q_valid;
    logic [4:0]  q0_rs, q0_rt, q0_dst, q1_rs, q1_rt, q1_dst;
    logic        q0_wen, q0_br, q0_mem, q0_priv, q1_wen, q1_br, q1_mem, q1_priv;
    logic [1:0]  pop;
    logic        q_flush, pipe_flush, iss0_valid, iss1_valid, iss0_in_ds, iss1_in_ds, ds_pending;
    logic [31:0] perf_dual, perf_single;
    logic [8:0]  o;
    int checks = 0;
    int errors = 0;

    issue_ctrl dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .exception_flush(exception_flush),
        .q_valid(q_valid),
        .q0_rs(q0_rs), .q0_rt(q0_rt), .q0_wen(q0_wen), .q0_dst(q0_dst),
        .q0_br(q0_br), .q0_mem(q0_mem), .q0_priv(q0_priv),
        .q1_rs(q1_rs), .q1_rt(q1_rt), .q1_wen(q1_wen), .q1_dst(q1_dst),
        .q1_br(q1_br), .q1_mem(q1_mem), .q1_priv(q1_priv),
        .pop(pop), .q_flush(q_flush), .pipe_flush(pipe_flush),
        .iss0_valid(iss0_valid), .iss1_valid(iss1_valid),
        .iss0_in_ds(iss0_in_ds), .iss1_in_ds(iss1_in_ds), .ds_pending(ds_pending),
        .perf_dual(perf_dual), .perf_single(perf_single)
    );

    always #5 clk = ~clk;

    // {pop, q_flush, pipe_flush, iss0_valid, iss1_valid, iss0_in_ds, iss1_in_ds, ds_pending}
    assign o = {pop, q_flush, pipe_flush, iss0_valid, iss1_valid, iss0_in_ds, iss1_in_ds, ds_pending};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        stall = 0; flush = 0; exception_flush = 0; q_valid = 2'b00;
        q0_rs = 0; q0_rt = 0; q0_wen = 0; q0_dst = 0; q0_br = 0; q0_mem = 0; q0_priv = 0;
        q1_rs = 0; q1_rt = 0; q1_wen = 0; q1_dst = 0; q1_br = 0; q1_mem = 0; q1_priv = 0;
    endtask

    task automatic put0(input logic [4:0] rs, rt, input logic wen, input logic [4:0] dst,
                        input logic br, mem, priv);
        q0_rs = rs; q0_rt = rt; q0_wen = wen; q0_dst = dst; q0_br = br; q0_mem = mem; q0_priv = priv;
    endtask

    task automatic put1(input logic [4:0] rs, rt, input logic wen, input logic [4:0] dst,
                        input logic br, mem, priv);
        q1_rs = rs; q1_rt = rt; q1_wen = wen; q1_dst = dst; q1_br = br; q1_mem = mem; q1_priv = priv;
    endtask

    task automatic test_reset();
        clear_in();
        rst = 1;
        tick();
        put0(1, 2, 1, 3, 0, 0, 0); put1(4, 5, 1, 6, 0, 0, 0); q_valid = 2'b11; flush = 1;
        #1;
        checks++;
        if (o !== 9'b00_00_00_00_0) begin errors++; $display("FAIL reset_outs: got %b exp %b", o, 9'b0); end
        checks++;
        if ({perf_dual, perf_single} !== 64'd0) begin errors++; $display("FAIL reset_perf: got %0d/%0d exp 0/0", perf_dual, perf_single); end
        tick();
        rst = 0; clear_in();
        tick();
    endtask

    task automatic test_pairing();
        put0(1, 2, 1, 3, 0, 0, 0); put1(4, 5, 1, 6, 0, 0, 0); q_valid = 2'b11; #1;
        checks++;
        if (o !== 9'b10_00_11_00_0) begin errors++; $display("FAIL dual_indep: got %b exp %b", o, 9'b10_00_11_00_0); end
        tick();
        put1(3, 5, 1, 6, 0, 0, 0); #1;
        checks++;
        if (o !== 9'b01_00_10_00_0) begin errors++; $display("FAIL raw_rs: got %b exp %b", o, 9'b01_00_10_00_0); end
        tick();
        put1(4, 3, 1, 6, 0, 0, 0); #1;
        checks++;
        if (o !== 9'b01_00_10_00_0) begin errors++; $display("FAIL raw_rt: got %b exp %b", o, 9'b01_00_10_00_0); end
        tick();
        put1(4, 5, 1, 3, 0, 0, 0); #1;
        checks++;
        if (o !== 9'b01_00_10_00_0) begin errors++; $display("FAIL waw: got %b exp %b", o, 9'b01_00_10_00_0); end
        tick();
        put0(1, 2, 1, 0, 0, 0, 0); put1(0, 0, 1, 0, 0, 0, 0); #1;
        checks++;
        if (o !== 9'b10_00_11_00_0) begin errors++; $display("FAIL dst_zero: got %b exp %b", o, 9'b10_00_11_00_0); end
        tick();
        put0(1, 2, 1, 3, 0, 0, 0); put1(4, 5, 0, 0, 1, 0, 0); #1;
        checks++;
        if (o !== 9'b01_00_10_00_0) begin errors++; $display("FAIL slot1_branch: got %b exp %b", o, 9'b01_00_10_00_0); end
        tick();
        put1(4, 5, 1, 6, 0, 0, 0); q_valid = 2'b01; #1;
        checks++;
        if (o !== 9'b01_00_10_00_0) begin errors++; $display("FAIL one_valid: got %b exp %b", o, 9'b01_00_10_00_0); end
        tick();
        q_valid = 2'b00; #1;
        checks++;
        if (o !== 9'b00_00_00_00_0) begin errors++; $display("FAIL empty: got %b exp %b", o, 9'b0); end
        tick();
        clear_in();
    endtask

    task automatic test_delay_slot();
        put0(1, 2, 0, 0, 1, 0, 0); q_valid = 2'b01; #1;
        checks++;
        if (o !== 9'b01_00_10_00_0) begin errors++; $display("FAIL br_alone: got %b exp %b", o, 9'b01_00_10_00_0); end
        tick();
        q_valid = 2'b00; flush = 1; #1;
        checks++;
        if (o !== 9'b00_00_00_00_1) begin errors++; $display("FAIL ds_flush_defer: got %b exp %b", o, 9'b00_00_00_00_1); end
        tick();
        flush = 0; #1;
        checks++;
        if (o !== 9'b00_00_00_00_1) begin errors++; $display("FAIL ds_wait: got %b exp %b", o, 9'b00_00_00_00_1); end
        tick();
        put0(1, 2, 1, 3, 0, 0, 0); q_valid = 2'b01; #1;
        checks++;
        if (o !== 9'b01_10_10_10_1) begin errors++; $display("FAIL ds_issue_qflush: got %b exp %b", o, 9'b01_10_10_10_1); end
        tick();
        q_valid = 2'b00; #1;
        checks++;
        if (o !== 9'b00_00_00_00_0) begin errors++; $display("FAIL ds_back_run: got %b exp %b", o, 9'b0); end
        put0(1, 2, 0, 0, 1, 0, 0); put1(4, 5, 0, 0, 0, 0, 1); q_valid = 2'b11; #1;
        checks++;
        if (o !== 9'b01_00_10_00_0) begin errors++; $display("FAIL br_priv_pair: got %b exp %b", o, 9'b01_00_10_00_0); end
        tick();
        put0(1, 2, 1, 3, 1, 0, 0); put1(4, 5, 1, 6, 0, 0, 0); #1;
        checks++;
        if (o !== 9'b01_00_10_10_1) begin errors++; $display("FAIL ds_single_noflush: got %b exp %b", o, 9'b01_00_10_10_1); end
        tick();
        q_valid = 2'b00; #1;
        checks++;
        if (o !== 9'b00_00_00_00_0) begin errors++; $display("FAIL ds_branch_ignored: got %b exp %b", o, 9'b0); end
        clear_in();
    endtask

    task automatic test_branch_pair();
        put0(1, 2, 0, 0, 1, 0, 0); put1(0, 0, 0, 0, 0, 0, 0); q_valid = 2'b11; #1;
        checks++;
        if (o !== 9'b10_00_11_01_0) begin errors++; $display("FAIL br_nop_pair: got %b exp %b", o, 9'b10_00_11_01_0); end
        tick();
        flush = 1; #1;
        checks++;
        if (o !== 9'b00_11_00_00_0) begin errors++; $display("FAIL run_flush: got %b exp %b", o, 9'b00_11_00_00_0); end
        tick();
        clear_in();
    endtask

    task automatic test_stall();
        put0(1, 2, 1, 3, 0, 0, 0); put1(4, 5, 1, 6, 0, 0, 0); q_valid = 2'b11; stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (o !== 9'b00_00_00_00_0) begin errors++; $display("FAIL stall_%0d: got %b exp %b", i, o, 9'b0); end
            tick();
        end
        stall = 0; put0(1, 2, 0, 0, 1, 0, 0); q_valid = 2'b01;
        tick();
        stall = 1; flush = 1; q_valid = 2'b00; #1;
        checks++;
        if (o !== 9'b00_00_00_00_1) begin errors++; $display("FAIL stall_in_ds: got %b exp %b", o, 9'b00_00_00_00_1); end
        tick();
        stall = 0; flush = 0; put0(1, 2, 1, 3, 0, 0, 0); q_valid = 2'b01; #1;
        checks++;
        if (o !== 9'b01_00_10_10_1) begin errors++; $display("FAIL stall_flush_ignored: got %b exp %b", o, 9'b01_00_10_10_1); end
        tick();
        put0(1, 2, 0, 0, 1, 0, 0);
        tick();
        q_valid = 2'b00; flush = 1;
        tick();
        flush = 0; stall = 1; exception_flush = 1; #1;
        checks++;
        if (o !== 9'b00_11_00_00_1) begin errors++; $display("FAIL exc_in_stall: got %b exp %b", o, 9'b00_11_00_00_1); end
        tick();
        stall = 0; exception_flush = 0; #1;
        checks++;
        if (o !== 9'b00_00_00_00_0) begin errors++; $display("FAIL exc_to_run: got %b exp %b", o, 9'b0); end
        q_valid = 2'b01;
        tick();
        put0(1, 2, 1, 3, 0, 0, 0); #1;
        checks++;
        if (o !== 9'b01_00_10_10_1) begin errors++; $display("FAIL exc_clears_pend: got %b exp %b", o, 9'b01_00_10_10_1); end
        tick();
        clear_in();
    endtask

    task automatic test_resources();
        put0(29, 0, 1, 8, 0, 1, 0); put1(0, 0, 1, 9, 0, 0, 1); q_valid = 2'b11; #1;
        checks++;
        if (o !== 9'b01_00_10_00_0) begin errors++; $display("FAIL lw_mfhi: got %b exp %b", o, 9'b01_00_10_00_0); end
        tick();
        put1(29, 10, 0, 0, 0, 1, 0); #1;
        checks++;
        if (o !== 9'b01_00_10_00_0) begin errors++; $display("FAIL lw_sw: got %b exp %b", o, 9'b01_00_10_00_0); end
        tick();
        put1(4, 5, 1, 6, 0, 0, 0); #1;
        checks++;
        if (o !== 9'b10_00_11_00_0) begin errors++; $display("FAIL lw_addu: got %b exp %b", o, 9'b10_00_11_00_0); end
        tick();
        put0(0, 0, 1, 9, 0, 0, 1); #1;
        checks++;
        if (o !== 9'b10_00_11_00_0) begin errors++; $display("FAIL priv_slot0: got %b exp %b", o, 9'b10_00_11_00_0); end
        tick();
        put0(1, 2, 0, 0, 1, 0, 0); q_valid = 2'b01;
        tick();
        rst = 1; #1;
        checks++;
        if (o !== 9'b00_00_00_00_0) begin errors++; $display("FAIL rst_in_ds: got %b exp %b", o, 9'b0); end
        tick();
        rst = 0; q_valid = 2'b00; #1;
        checks++;
        if (o !== 9'b00_00_00_00_0) begin errors++; $display("FAIL after_rst: got %b exp %b", o, 9'b0); end
        tick();
        clear_in();
    endtask

    task automatic test_perf();
        put0(1, 2, 1, 3, 0, 0, 0); put1(4, 5, 1, 6, 0, 0, 0); q_valid = 2'b11;
        tick();
        q_valid = 2'b01;
        tick();
        q_valid = 2'b11; exception_flush = 1;
        tick();
        clear_in(); #1;
        checks++;
`ifdef ISSUE_PERF_CNT_EN
        if (perf_dual !== 32'd1 || perf_single !== 32'd1) begin errors++; $display("FAIL perf: got %0d/%0d exp 1/1", perf_dual, perf_single); end
`else
        if (perf_dual !== 32'd0 || perf_single !== 32'd0) begin errors++; $display("FAIL perf_off: got %0d/%0d exp 0/0", perf_dual, perf_single); end
`endif
    endtask

    initial begin
        test_reset();
        test_pairing();
        test_delay_slot();
        test_branch_pair();
        test_stall();
        test_resources();
        test_perf();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
